// File: rtl/merge_unit_2to1.sv
// Two-input merger of ascending-sorted runs into one ascending-sorted run.
// FWFT pop handshakes on the inputs, one-entry registered output stage.
module merge_unit_2to1 #(
  parameter int KEY_WIDTH = 32,
  parameter int VAL_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_WIDTH-1:0] a_key,
  input  logic [VAL_WIDTH-1:0] a_val,
  input  logic                 a_last,
  input  logic                 a_data_vld,
  output logic                 a_read,
  input  logic [KEY_WIDTH-1:0] b_key,
  input  logic [VAL_WIDTH-1:0] b_val,
  input  logic                 b_last,
  input  logic                 b_data_vld,
  output logic                 b_read,
  output logic [KEY_WIDTH-1:0] m_key,
  output logic [VAL_WIDTH-1:0] m_val,
  output logic                 m_last,
  output logic                 m_data_vld,
  input  logic                 m_read,
  output logic [31:0]          run_cnt
);

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   m_data_vld_q;
  logic [KEY_WIDTH-1:0]   m_key_q;
  logic [VAL_WIDTH-1:0]   m_val_q;
  logic                   m_last_q;
  logic [31:0]            run_cnt_q;

  logic out_ready;
  logic a_wins;
  logic pop_a, pop_b, pop_last;

  assign out_ready = !m_data_vld_q || m_read;
  assign a_wins    = (a_key <= b_key);  // ties go to A to keep the merge stable

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    pop_a    = 1'b0;
    pop_b    = 1'b0;
    pop_last = 1'b0;
    state_d  = state_q;
    if (!rst && out_ready) begin
      case (state_q)
        MERGE: begin
          if (a_data_vld && b_data_vld) begin
            pop_a = a_wins;
            pop_b = !a_wins;
          end
          if (pop_a && a_last)      state_d = DRAIN_B;
          else if (pop_b && b_last) state_d = DRAIN_A;
        end
        DRAIN_A: begin
          pop_a    = a_data_vld;
          pop_last = a_last;
          if (pop_a && a_last) state_d = MERGE;
        end
        DRAIN_B: begin
          pop_b    = b_data_vld;
          pop_last = b_last;
          if (pop_b && b_last) state_d = MERGE;
        end
        default: state_d = MERGE;
      endcase
    end
  end

  assign a_read = pop_a;
  assign b_read = pop_b;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MERGE;
      m_data_vld_q <= 1'b0;
      m_key_q      <= '0;
      m_val_q      <= '0;
      m_last_q     <= 1'b0;
      run_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (pop_a || pop_b) begin
        m_data_vld_q <= 1'b1;
        m_key_q      <= pop_a ? a_key : b_key;
        m_val_q      <= pop_a ? a_val : b_val;
        m_last_q     <= pop_last;
        if (pop_last) run_cnt_q <= run_cnt_q + 32'd1;
      end else if (m_read) begin
        m_data_vld_q <= 1'b0;
      end
    end
  end

  assign m_key      = m_key_q;
  assign m_val      = m_val_q;
  assign m_last     = m_last_q;
  assign m_data_vld = m_data_vld_q;
  assign run_cnt    = run_cnt_q;

endmodule

// File: tb/tb_merge_unit_2to1.sv
// Self-checking bench for merge_unit_2to1: directed scenarios plus random runs
// compared against a stable-merge reference model built from plain queues.
module tb_merge_unit_2to1;

  localparam int KW = 32;
  localparam int VW = 32;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [VW-1:0] val;
    logic          last;
  } rec_t;

  logic          clk;
  logic          rst;
  logic [KW-1:0] a_key, b_key, m_key;
  logic [VW-1:0] a_val, b_val, m_val;
  logic          a_last, b_last, m_last;
  logic          a_data_vld, b_data_vld, m_data_vld;
  logic          a_read, b_read, m_read;
  logic [31:0]   run_cnt;

  merge_unit_2to1 #(.KEY_WIDTH(KW), .VAL_WIDTH(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_key      (a_key),
    .a_val      (a_val),
    .a_last     (a_last),
    .a_data_vld (a_data_vld),
    .a_read     (a_read),
    .b_key      (b_key),
    .b_val      (b_val),
    .b_last     (b_last),
    .b_data_vld (b_data_vld),
    .b_read     (b_read),
    .m_key      (m_key),
    .m_val      (m_val),
    .m_last     (m_last),
    .m_data_vld (m_data_vld),
    .m_read     (m_read),
    .run_cnt    (run_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_runs = 0;
  rec_t a_q[$], b_q[$], exp_q[$];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one run on each input and append the expected stable merge of both.
  task automatic add_pair(input int unsigned ka[$], input int unsigned kb[$],
                          input int unsigned va, input int unsigned vb);
    rec_t ra[$], rb[$], r;
    int   i, j;
    foreach (ka[k]) begin
      r.key = ka[k]; r.val = va + k; r.last = (k == ka.size() - 1);
      ra.push_back(r); a_q.push_back(r);
    end
    foreach (kb[k]) begin
      r.key = kb[k]; r.val = vb + k; r.last = (k == kb.size() - 1);
      rb.push_back(r); b_q.push_back(r);
    end
    i = 0; j = 0;
    while (i < ra.size() || j < rb.size()) begin
      if (j >= rb.size() || (i < ra.size() && ra[i].key <= rb[j].key)) begin
        r = ra[i]; i++;
      end else begin
        r = rb[j]; j++;
      end
      r.last = (i == ra.size() && j == rb.size());
      exp_q.push_back(r);
    end
    exp_runs++;
  endtask

  task automatic add_random_pair();
    int unsigned ka[$], kb[$];
    int unsigned base, k;
    int          n;
    base = $urandom_range(32'h7FFF_FF00, 0);
    k = base;
    n = $urandom_range(6, 1);
    for (int i = 0; i < n; i++) begin k += $urandom_range(3, 0); ka.push_back(k); end
    k = ($urandom_range(1, 0) == 0) ? base : (base ^ 32'h8000_0000);
    n = $urandom_range(6, 1);
    for (int i = 0; i < n; i++) begin k += $urandom_range(3, 0); kb.push_back(k); end
    add_pair(ka, kb, $urandom, $urandom);
  endtask

  // Drive sources from the queues, consume and check outputs, until expectations drain.
  task automatic run(input int max_cycles, input int stop_after, input int gap_pct,
                     input int stall_mode, input int stall_pct, input int b_starve,
                     input bit full_rate);
    int   cyc = 0;
    int   acc = 0;
    int   starve = b_starve;
    bit   started = 1'b0;
    bit   held = 1'b0;
    bit   starving, pa, pb;
    rec_t held_rec, cur;
    while (exp_q.size() > 0 && (stop_after < 0 || acc < stop_after) && cyc < max_cycles) begin
      @(negedge clk);
      a_data_vld = (a_q.size() > 0) && ($urandom_range(99, 0) >= gap_pct);
      b_data_vld = (b_q.size() > 0) && ($urandom_range(99, 0) >= gap_pct);
      starving = (starve > 0);
      if (starving) begin b_data_vld = 1'b0; starve--; end
      {a_key, a_val, a_last} = a_data_vld ? a_q[0] : rec_t'({$urandom, $urandom, 1'b1});
      {b_key, b_val, b_last} = b_data_vld ? b_q[0] : rec_t'({$urandom, $urandom, 1'b1});
      if (stall_mode == 1) m_read = (cyc % 3 == 0);
      else                 m_read = ($urandom_range(99, 0) >= stall_pct);
      #1;
      cur = {m_key, m_val, m_last};
      if (held) begin
        check("hold_vld", m_data_vld, 1'b1);
        check("hold_rec", cur, held_rec);
      end
      if (starving) check("starve_no_pop", {a_read, b_read}, 2'b00);
      if (m_data_vld && !m_read) check("bp_no_pop", {a_read, b_read}, 2'b00);
      if (a_read && b_read) check("read_excl", {a_read, b_read}, 2'b10);
      if (full_rate && started) check("no_bubble", m_data_vld, 1'b1);
      if (m_data_vld && m_read) begin
        check("out_rec", cur, exp_q.pop_front());
        acc++;
        started = 1'b1;
      end
      held = m_data_vld && !m_read;
      held_rec = cur;
      pa = a_read && a_data_vld;
      pb = b_read && b_data_vld;
      @(posedge clk);
      if (pa && a_q.size() > 0) void'(a_q.pop_front());
      if (pb && b_q.size() > 0) void'(b_q.pop_front());
      #1;
      cyc++;
    end
    if (stop_after < 0) check("drain_timeout", exp_q.size(), 0);
    else                check("stop_timeout", acc, stop_after);
  endtask

  initial begin
    int unsigned ka[$], kb[$];

    // Reset values and popping suppressed while reset is held, even with valid inputs.
    rst = 1'b1;
    a_data_vld = 1'b1; b_data_vld = 1'b1; m_read = 1'b1;
    a_key = 32'd1; a_val = 32'd0; a_last = 1'b0;
    b_key = 32'd2; b_val = 32'd0; b_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vld", m_data_vld, 1'b0);
    check("rst_key", m_key, 32'd0);
    check("rst_val", m_val, 32'd0);
    check("rst_last", m_last, 1'b0);
    check("rst_run_cnt", run_cnt, 32'd0);
    check("rst_reads", {a_read, b_read}, 2'b00);
    a_data_vld = 1'b0; b_data_vld = 1'b0;
    rst = 1'b0;

    // Basic interleave at full rate.
    ka = '{1, 4, 7}; kb = '{2, 3, 9};
    add_pair(ka, kb, 32'h100, 32'h200);
    run(200, -1, 0, 0, 0, 0, 1'b1);
    check("basic_run_cnt", run_cnt, exp_runs);

    // Equal keys: A's record leaves first.
    ka = '{5}; kb = '{5};
    add_pair(ka, kb, 32'hA, 32'hB);
    run(200, -1, 0, 0, 0, 0, 1'b1);
    check("tie_run_cnt", run_cnt, exp_runs);

    // Backpressure with m_read pattern 1,0,0,1,0,0...
    ka = '{1, 4, 7}; kb = '{2, 3, 9};
    add_pair(ka, kb, 32'h300, 32'h400);
    run(400, -1, 0, 1, 0, 0, 1'b0);
    check("bp_run_cnt", run_cnt, exp_runs);

    // B starved for three cycles while A is valid.
    ka = '{1, 4, 7}; kb = '{2, 3, 9};
    add_pair(ka, kb, 32'h500, 32'h600);
    run(200, -1, 0, 0, 0, 3, 1'b0);
    check("starve_run_cnt", run_cnt, exp_runs);

    // Two run pairs back to back, no idle cycle allowed at the boundary.
    ka = '{3, 8};  kb = '{1, 8, 10};
    add_pair(ka, kb, 32'h700, 32'h800);
    ka = '{32'h8000_0000}; kb = '{32'h7FFF_FFFF, 32'hFFFF_FFFF};
    add_pair(ka, kb, 32'h900, 32'hA00);
    run(200, -1, 0, 0, 0, 0, 1'b1);
    check("b2b_run_cnt", run_cnt, exp_runs);

    // Random runs with input gaps and random downstream stalls.
    for (int p = 0; p < 40; p++) add_random_pair();
    run(20000, -1, 25, 0, 35, 0, 1'b0);
    check("rand_run_cnt", run_cnt, exp_runs);

    // Reset in the middle of a run discards it.
    ka = '{1, 4, 7}; kb = '{2, 3, 9};
    add_pair(ka, kb, 32'hB00, 32'hC00);
    run(200, 2, 0, 0, 0, 0, 1'b0);
    a_data_vld = 1'b1; b_data_vld = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_vld", m_data_vld, 1'b0);
    check("midrst_run_cnt", run_cnt, 32'd0);
    check("midrst_reads", {a_read, b_read}, 2'b00);
    a_q.delete(); b_q.delete(); exp_q.delete();
    exp_runs = 0;
    @(negedge clk);
    a_data_vld = 1'b0; b_data_vld = 1'b0;
    rst = 1'b0;
    ka = '{1}; kb = '{2};
    add_pair(ka, kb, 32'hD00, 32'hE00);
    run(200, -1, 0, 0, 0, 0, 1'b1);
    check("fresh_run_cnt", run_cnt, exp_runs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
